// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch sequencer owning the PC; arbitrates EX redirects, load-use stalls and imem waits, drives pipeline flush/stall and perf counters.
// Ports: cpu_clk/cpu_rst clock and sync active-high reset; ex_valid/ex_jump_type/ex_br EX-stage control flow;
//   hz_stall load-use stall; imem_ready fetch handshake; npc next-PC unit result; npc_op/npc_br next-PC unit controls;
//   pc fetch PC; imem_req fetch request; if_valid good-path fetch; stall_ifid/flush_ifid/flush_idex pipeline controls;
//   redir_cnt/stall_cnt saturating performance counters.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_jump_type,
  input  logic             ex_br,
  input  logic             hz_stall,
  input  logic             imem_ready,
  input  logic [31:0]      npc,
  output logic [1:0]       npc_op,
  output logic             npc_br,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             if_valid,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, REDIR_PEND} state_t;
  state_t state;
  logic [31:0] pend_target;
  logic redirect, act, rw, pend, stall;
  always_comb begin
    redirect = ex_valid & (ex_jump_type[0] | (ex_jump_type == 2'b10 & ex_br));
    act = ~cpu_rst;
    rw = act & (state == RUN | state == WAIT_MEM);
    pend = act & state == REDIR_PEND;
    stall = rw & ~redirect & hz_stall;
    npc_op = (act & redirect) ? ex_jump_type : 2'b00;
    npc_br = act & redirect & ex_br;
    imem_req = rw | pend;
    if_valid = rw & ~redirect & ~hz_stall & imem_ready;
    stall_ifid = stall;
    flush_ifid = (rw & redirect) | pend;
    flush_idex = rw & (redirect | hz_stall);
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc <= RESET_PC;
      state <= BOOT;
      pend_target <= '0;
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state != BOOT && redirect && !(&redir_cnt)) redir_cnt <= redir_cnt + 1'b1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        BOOT: state <= RUN;
        RUN, WAIT_MEM: begin
          if (redirect) begin
            if (imem_ready) begin
              pc <= npc;
              state <= RUN;
            end else begin
              pend_target <= npc;
              state <= REDIR_PEND;
            end
          end else if (!hz_stall) begin
            if (imem_ready) begin
              pc <= npc;
              state <= RUN;
            end else state <= WAIT_MEM;
          end
        end
        default: begin
          // a late redirect supersedes the parked target, even on the drain cycle
          if (imem_ready) begin
            pc <= redirect ? npc : pend_target;
            state <= RUN;
          end else if (redirect) pend_target <= npc;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed-vector bench for pc_seq_ctrl with a behavioural next-PC unit.
module tb_pc_seq_ctrl;
  logic cpu_clk = 0, cpu_rst = 1;
  logic ex_valid = 0, ex_br = 0, hz_stall = 0, imem_ready = 1;
  logic [1:0] ex_jump_type = 0;
  logic [31:0] npc, pc, tgt = 0;
  logic [1:0] npc_op;
  logic npc_br, imem_req, if_valid, stall_ifid, flush_ifid, flush_idex;
  logic [15:0] redir_cnt, stall_cnt;
  int n_vec = 0, n_err = 0;
  pc_seq_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ex_valid(ex_valid), .ex_jump_type(ex_jump_type),
    .ex_br(ex_br), .hz_stall(hz_stall), .imem_ready(imem_ready), .npc(npc), .npc_op(npc_op),
    .npc_br(npc_br), .pc(pc), .imem_req(imem_req), .if_valid(if_valid), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .redir_cnt(redir_cnt), .stall_cnt(stall_cnt)
  );
  always #5 cpu_clk = ~cpu_clk;
  assign npc = (npc_op == 2'b00) ? pc + 32'd4 : tgt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic redir(input logic [1:0] t, input logic b, input logic [31:0] a);
    ex_valid = 1; ex_jump_type = t; ex_br = b; tgt = a;
    #1;
  endtask
  task automatic quiet;
    ex_valid = 0; ex_jump_type = 0; ex_br = 0; hz_stall = 0;
    #1;
  endtask
  initial begin
    tick; tick;
    chk("rst_req", imem_req, 0);
    chk("rst_flush", flush_ifid, 0);
    cpu_rst = 0; #1;
    chk("boot_pc", pc, 0);
    chk("boot_req", imem_req, 0);
    chk("boot_valid", if_valid, 0);
    tick;
    chk("run0_pc", pc, 0);
    chk("run0_req", imem_req, 1);
    chk("run0_valid", if_valid, 1);
    tick;
    chk("run1_pc", pc, 32'h4);
    chk("run1_valid", if_valid, 1);
    tick;
    chk("run2_pc", pc, 32'h8);
    tick; tick;
    chk("at10", pc, 32'h10);
    redir(2'b10, 0, 32'h40);
    chk("nt_op", npc_op, 0);
    chk("nt_flush", flush_ifid, 0);
    chk("nt_valid", if_valid, 1);
    tick;
    chk("nt_pc", pc, 32'h14);
    chk("nt_cnt", redir_cnt, 0);
    redir(2'b10, 1, 32'h40);
    chk("br_op", npc_op, 2'b10);
    chk("br_br", npc_br, 1);
    chk("br_fifid", flush_ifid, 1);
    chk("br_fidex", flush_idex, 1);
    chk("br_valid", if_valid, 0);
    tick;
    chk("br_pc", pc, 32'h40);
    chk("br_cnt", redir_cnt, 1);
    quiet;
    hz_stall = 1; #1;
    chk("st_sifid", stall_ifid, 1);
    chk("st_fidex", flush_idex, 1);
    chk("st_fifid", flush_ifid, 0);
    chk("st_valid", if_valid, 0);
    tick;
    imem_ready = 0; #1;
    tick;
    chk("st_pc", pc, 32'h40);
    chk("st_cnt", stall_cnt, 2);
    hz_stall = 0; imem_ready = 1; #1;
    tick;
    chk("st_after", pc, 32'h44);
    hz_stall = 1;
    redir(2'b11, 0, 32'h100);
    chk("rs_sifid", stall_ifid, 0);
    chk("rs_fifid", flush_ifid, 1);
    chk("rs_op", npc_op, 2'b11);
    tick;
    chk("rs_pc", pc, 32'h100);
    chk("rs_scnt", stall_cnt, 2);
    chk("rs_rcnt", redir_cnt, 2);
    quiet;
    imem_ready = 0; #1;
    chk("wm_valid", if_valid, 0);
    tick;
    chk("wm_pc", pc, 32'h100);
    redir(2'b01, 0, 32'h200);
    chk("wm_fifid", flush_ifid, 1);
    chk("wm_op", npc_op, 2'b01);
    tick;
    chk("rp_pc", pc, 32'h100);
    chk("rp_rcnt", redir_cnt, 3);
    quiet;
    chk("rp_fifid", flush_ifid, 1);
    chk("rp_req", imem_req, 1);
    tick;
    chk("rp_hold", pc, 32'h100);
    imem_ready = 1; #1;
    chk("rp_valid", if_valid, 0);
    chk("rp_fidex", flush_idex, 0);
    tick;
    chk("rp_pc2", pc, 32'h200);
    chk("rp_rv", if_valid, 1);
    tick;
    chk("rp_pc3", pc, 32'h204);
    hz_stall = 1; #1;
    for (int i = 0; i < 65533; i++) tick;
    chk("sat_max", stall_cnt, 16'hffff);
    tick;
    chk("sat_hold", stall_cnt, 16'hffff);
    chk("sat_pc", pc, 32'h204);
    quiet;
    imem_ready = 0;
    redir(2'b01, 0, 32'h300);
    tick;
    quiet;
    chk("mr_pend", flush_ifid, 1);
    cpu_rst = 1; #1;
    chk("mr_req", imem_req, 0);
    chk("mr_fifid", flush_ifid, 0);
    tick;
    chk("mr_pc", pc, 0);
    chk("mr_scnt", stall_cnt, 0);
    chk("mr_rcnt", redir_cnt, 0);
    cpu_rst = 0; imem_ready = 1; #1;
    tick;
    chk("mr_boot", pc, 0);
    tick;
    chk("mr_run", pc, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
